// File: rtl/ceres_param.sv
// Shared bus types and constants for the core memory subsystem.
// Holds the Wishbone B4 pipelined structs and the RAM arbiter state type.
package ceres_param;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = WB_DW / 8;

  // Request: accepted on the cycle where cyc && stb && !stall (valid/ready handshake).
  typedef struct packed {
    logic             cyc;
    logic             stb;
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
    logic [WB_SW-1:0] sel;
  } wb_master_t;

  typedef struct packed {
    logic             ack;
    logic             err;
    logic             rty;
    logic             stall;
    logic [WB_DW-1:0] dat;
  } wb_slave_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    DRAIN  = 2'd3
  } arb_state_e;

  localparam int unsigned WB_ARB_MAX_OUTST = 4;

endpackage

// File: rtl/wb_arb_rr_picker.sv
// Two-way request picker: round-robin on ties (against the last winner) or
// fixed priority with m0 first. Output is one-hot, zero when nobody requests.
module wb_arb_rr_picker #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_i,
  output logic [1:0] pick_o
);

  always_comb begin
    pick_o = {req1_i, req0_i};
    if (req0_i && req1_i) begin
      // last_i = 1 means m1 won last time, so m0 takes this tie.
      pick_o = (ROUND_ROBIN && !last_i) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone B4 pipelined arbiter in front of the on-chip RAM.
// Ownership lasts a whole bus cycle; outstanding requests are tracked so late responses never leak.
module wb_ram_arbiter
  import ceres_param::*;
#(
  parameter int unsigned MAX_OUTST   = WB_ARB_MAX_OUTST,
  parameter bit          ROUND_ROBIN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  wb_master_t m0_i,
  output wb_slave_t  m0_o,
  input  wb_master_t m1_i,
  output wb_slave_t  m1_o,
  output wb_master_t s_o,
  input  wb_slave_t  s_i,
  output logic [1:0] gnt_o,
  output logic       busy_o,
  output arb_state_e state_o
);

  localparam int unsigned CW = $clog2(MAX_OUTST + 1);

  arb_state_e    state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q;
  logic [1:0]    gnt_q;
  logic          busy_q;

  logic          limit;
  logic          accept;
  logic          resp;
  logic [1:0]    pick;
  wb_master_t    own_req;
  wb_slave_t     own_rsp;
  wb_slave_t     idle_rsp;

  wb_arb_rr_picker #(
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_picker (
    .req0_i(m0_i.cyc),
    .req1_i(m1_i.cyc),
    .last_i(last_q),
    .pick_o(pick)
  );

  assign limit   = (cnt_q == CW'(MAX_OUTST));
  assign resp    = s_i.ack | s_i.err | s_i.rty;
  assign own_req = (state_q == GRANT1) ? m1_i : m0_i;

  always_comb begin
    idle_rsp       = '0;
    idle_rsp.stall = 1'b1;
    idle_rsp.dat   = s_i.dat;
    own_rsp        = s_i;
    own_rsp.stall  = s_i.stall | limit;
  end

  // Only a granted owner reaches the slave; IDLE and DRAIN keep the bus quiet.
  always_comb begin
    s_o  = '0;
    m0_o = idle_rsp;
    m1_o = idle_rsp;
    if (state_q == GRANT0 || state_q == GRANT1) begin
      s_o     = own_req;
      s_o.stb = own_req.stb & ~limit;
    end
    if (state_q == GRANT0) m0_o = own_rsp;
    if (state_q == GRANT1) m1_o = own_rsp;
  end

  assign accept = s_o.cyc & s_o.stb & ~s_i.stall;

  // Responses with nothing outstanding (e.g. stragglers from before a reset) do not underflow.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !resp) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!accept && resp && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (pick[0]) begin
            state_q <= GRANT0;
            last_q  <= 1'b0;
            gnt_q   <= 2'b01;
            busy_q  <= 1'b1;
          end else if (pick[1]) begin
            state_q <= GRANT1;
            last_q  <= 1'b1;
            gnt_q   <= 2'b10;
            busy_q  <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          if (!own_req.cyc) begin
            gnt_q <= 2'b00;
            if (cnt_d == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (cnt_d == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o   = gnt_q;
  assign busy_o  = busy_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: directed traffic against a delayed-response RAM slave,
// an ownership/outstanding model compared every cycle, and a per-master read-data queue.
`timescale 1ns/1ps
module tb_wb_ram_arbiter;
  import ceres_param::*;

  localparam int          MAXO   = 4;
  localparam logic [31:0] RD_KEY = 32'h5A5A_0000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_master_t m0_i, m1_i, s_o, fp_s_o;
  wb_slave_t  m0_o, m1_o, s_i, fp_m0_o, fp_m1_o, fp_s_i;
  logic [1:0] gnt_o, fp_gnt_o;
  logic       busy_o, fp_busy_o;
  arb_state_e state_o, fp_state_o;

  wb_ram_arbiter #(.MAX_OUTST(MAXO), .ROUND_ROBIN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_i(m0_i), .m0_o(m0_o), .m1_i(m1_i), .m1_o(m1_o),
    .s_o(s_o), .s_i(s_i),
    .gnt_o(gnt_o), .busy_o(busy_o), .state_o(state_o)
  );

  assign fp_s_i = '0;

  wb_ram_arbiter #(.MAX_OUTST(MAXO), .ROUND_ROBIN(1'b0)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_i(m0_i), .m0_o(fp_m0_o), .m1_i(m1_i), .m1_o(fp_m1_o),
    .s_o(fp_s_o), .s_i(fp_s_i),
    .gnt_o(fp_gnt_o), .busy_o(fp_busy_o), .state_o(fp_state_o)
  );

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- RAM slave: response delay cycles after acceptance ----------------
  typedef struct {
    int          due;
    logic [31:0] dat;
    int          kind;
  } pend_t;

  pend_t       pend_q[$];
  int          cyc_cnt   = 0;
  int          slv_delay = 1;
  logic        slv_stall = 1'b0;
  int          slv_kind  = 0;
  logic        head_v    = 1'b0;
  int          head_due  = 0;
  logic [31:0] head_dat  = '0;
  int          head_kind = 0;
  logic        smp_pop, smp_acc;
  logic [31:0] smp_dat;
  int          smp_due, smp_kind;

  always_comb begin
    s_i       = '0;
    s_i.stall = slv_stall;
    if (head_v && head_due == cyc_cnt) begin
      s_i.dat = head_dat;
      case (head_kind)
        1:       s_i.err = 1'b1;
        2:       s_i.rty = 1'b1;
        default: s_i.ack = 1'b1;
      endcase
    end else if (slv_delay == 0 && s_o.cyc && s_o.stb && !slv_stall) begin
      s_i.ack = 1'b1;
      s_i.dat = s_o.adr ^ RD_KEY;
    end
  end

  initial forever begin
    @(posedge clk);
    smp_pop  = head_v && (head_due == cyc_cnt);
    smp_acc  = s_o.cyc && s_o.stb && !s_i.stall && (slv_delay > 0);
    smp_dat  = s_o.adr ^ RD_KEY;
    smp_due  = cyc_cnt + slv_delay;
    smp_kind = slv_kind;
    #1;
    if (smp_pop) void'(pend_q.pop_front());
    if (smp_acc) pend_q.push_back('{smp_due, smp_dat, smp_kind});
    cyc_cnt++;
    head_v = (pend_q.size() > 0);
    if (head_v) begin
      head_due  = pend_q[0].due;
      head_dat  = pend_q[0].dat;
      head_kind = pend_q[0].kind;
    end
  end

  // ---------------- behavioural model + scoreboard ----------------
  int          mdl_owner = 0;   // 0 none, 1 m0, 2 m1
  bit          mdl_drain = 1'b0;
  int          mdl_out   = 0;
  int          mdl_last  = 1;   // index of the last granted master
  int          max_out   = 0;
  int          rsp_cnt0  = 0;
  int          rsp_cnt1  = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  task automatic score(input int m, input wb_slave_t rsp_o);
    logic [31:0] e;
    if (m == 0) begin
      rsp_cnt0++;
      if (exp_q0.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL m0_rsp: got a response, expected none outstanding (t=%0t)", $time);
      end else begin
        e = exp_q0.pop_front();
        chk("m0_rsp_dat", 128'(rsp_o.dat), 128'(e));
      end
    end else begin
      rsp_cnt1++;
      if (exp_q1.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL m1_rsp: got a response, expected none outstanding (t=%0t)", $time);
      end else begin
        e = exp_q1.pop_front();
        chk("m1_rsp_dat", 128'(rsp_o.dat), 128'(e));
      end
    end
  endtask

  task automatic model_step();
    wb_master_t own, exp_s;
    wb_slave_t  idle_r, own_r, exp0, exp1;
    logic [1:0] exp_gnt;
    logic       rsp, acc;
    int         w;
    if (!rst_n) begin
      mdl_owner = 0; mdl_drain = 1'b0; mdl_out = 0; mdl_last = 1;
      exp_q0.delete(); exp_q1.delete();
    end
    own          = (mdl_owner == 2) ? m1_i : m0_i;
    idle_r       = '0;
    idle_r.stall = 1'b1;
    idle_r.dat   = s_i.dat;
    exp_s        = '0;
    exp0         = idle_r;
    exp1         = idle_r;
    if (mdl_owner != 0) begin
      exp_s       = own;
      exp_s.stb   = own.stb && (mdl_out < MAXO);
      own_r       = s_i;
      own_r.stall = s_i.stall || (mdl_out >= MAXO);
      if (mdl_owner == 1) exp0 = own_r; else exp1 = own_r;
    end
    exp_gnt = (mdl_owner == 1) ? 2'b01 : (mdl_owner == 2) ? 2'b10 : 2'b00;
    chk("s_o", 128'(s_o), 128'(exp_s));
    chk("m0_o", 128'(m0_o), 128'(exp0));
    chk("m1_o", 128'(m1_o), 128'(exp1));
    chk("gnt_o", 128'(gnt_o), 128'(exp_gnt));
    chk("busy_o", 128'(busy_o), 128'((mdl_owner != 0) || mdl_drain));
    if (rst_n) begin
      rsp = s_i.ack | s_i.err | s_i.rty;
      acc = (mdl_owner != 0) && exp_s.cyc && exp_s.stb && !s_i.stall;
      if (acc) begin
        if (mdl_owner == 1) exp_q0.push_back(own.adr ^ RD_KEY);
        else                exp_q1.push_back(own.adr ^ RD_KEY);
      end
      if (rsp && mdl_owner == 1) score(0, m0_o);
      if (rsp && mdl_owner == 2) score(1, m1_o);
      if (acc) mdl_out++;
      if (rsp && mdl_out > 0) mdl_out--;
      if (mdl_out > max_out) max_out = mdl_out;
      if (mdl_owner != 0) begin
        if (!own.cyc) begin
          // Anything still in flight for this master is lost to it for good.
          if (mdl_owner == 1) exp_q0.delete(); else exp_q1.delete();
          mdl_owner = 0;
          mdl_drain = (mdl_out > 0);
        end
      end else if (mdl_drain) begin
        if (mdl_out == 0) mdl_drain = 1'b0;
      end else if (m0_i.cyc || m1_i.cyc) begin
        if (m0_i.cyc && m1_i.cyc) w = (mdl_last == 1) ? 0 : 1;
        else                      w = m0_i.cyc ? 0 : 1;
        mdl_owner = w + 1;
        mdl_last  = w;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  // ---------------- directed stimulus ----------------
  int acc_n, guard, base0, base1, swallowed;
  logic accepted;

  initial begin
    m0_i = '0;
    m1_i = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 128'(gnt_o), 128'(2'b00));
    chk("rst_busy", 128'(busy_o), 128'(1'b0));
    chk("rst_s_o", 128'(s_o), 128'(0));
    chk("rst_m0_stall", 128'(m0_o.stall), 128'(1'b1));
    chk("rst_m1_ack", 128'(m1_o.ack), 128'(1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Ties from reset: round-robin alternates, fixed priority keeps m0.
    for (int r = 0; r < 4; r++) begin
      m0_i.cyc = 1'b1;
      m1_i.cyc = 1'b1;
      step();
      @(negedge clk);
      chk($sformatf("rr_tie%0d", r), 128'(gnt_o), 128'((r % 2 == 0) ? 2'b01 : 2'b10));
      chk($sformatf("fp_tie%0d", r), 128'(fp_gnt_o), 128'(2'b01));
      step();
      m0_i.cyc = 1'b0;
      m1_i.cyc = 1'b0;
      step();
    end

    // Handoff: m0 wins, releases, one dead IDLE cycle, then m1.
    m0_i.cyc = 1'b1;
    m1_i.cyc = 1'b1;
    step();
    @(negedge clk);
    chk("hand_m0", 128'(gnt_o), 128'(2'b01));
    step();
    m0_i.cyc = 1'b0;
    step();
    @(negedge clk);
    chk("hand_dead", 128'(gnt_o), 128'(2'b00));
    step();
    @(negedge clk);
    chk("hand_m1", 128'(gnt_o), 128'(2'b10));
    step();
    m1_i.cyc = 1'b0;
    step();

    // Single m0 read at 0x100, one-cycle RAM latency.
    slv_delay = 1;
    m0_i = '{cyc: 1'b1, stb: 1'b1, we: 1'b0, adr: 32'h100, dat: 32'h0, sel: 4'hF};
    @(negedge clk);
    chk("t2_arb_stall", 128'(m0_o.stall), 128'(1'b1));
    chk("t2_arb_gnt", 128'(gnt_o), 128'(2'b00));
    step();
    @(negedge clk);
    chk("t2_gnt", 128'(gnt_o), 128'(2'b01));
    chk("t2_s_adr", 128'(s_o.adr), 128'(32'h100));
    chk("t2_stall", 128'(m0_o.stall), 128'(1'b0));
    step();
    m0_i.stb = 1'b0;
    @(negedge clk);
    chk("t2_ack", 128'(m0_o.ack), 128'(1'b1));
    chk("t2_dat", 128'(m0_o.dat), 128'(32'h5A5A_0100));
    step();
    m0_i.cyc = 1'b0;
    step();
    @(negedge clk);
    chk("t2_idle_gnt", 128'(gnt_o), 128'(2'b00));

    // m1 burst of 8 reads against a 4-deep limit, acks 4 cycles after acceptance.
    step();
    slv_delay = 4;
    max_out = 0;
    base1 = rsp_cnt1;
    acc_n = 0;
    guard = 0;
    m1_i = '{cyc: 1'b1, stb: 1'b1, we: 1'b0, adr: 32'h200, dat: 32'h0, sel: 4'hF};
    while (acc_n < 8 && guard < 200) begin
      @(negedge clk);
      accepted = m1_i.stb && !m1_o.stall;
      step();
      guard++;
      if (accepted) begin
        acc_n++;
        if (acc_n < 8) m1_i.adr = 32'h200 + 32'(acc_n * 4);
        else           m1_i.stb = 1'b0;
      end
    end
    chk("t3_accepts", 128'(acc_n), 128'(8));
    guard = 0;
    while ((rsp_cnt1 - base1) < 8 && guard < 100) begin
      step();
      guard++;
    end
    chk("t3_acks", 128'(rsp_cnt1 - base1), 128'(8));
    chk("t3_max_out", 128'(max_out), 128'(4));
    m1_i.cyc = 1'b0;
    step();
    step();

    // m1 write with same-cycle ack: count stays 0, straight back to IDLE.
    slv_delay = 0;
    m1_i = '{cyc: 1'b1, stb: 1'b1, we: 1'b1, adr: 32'h300, dat: 32'hDEAD_BEEF, sel: 4'hF};
    step();
    @(negedge clk);
    chk("t4_s_dat", 128'(s_o.dat), 128'(32'hDEAD_BEEF));
    chk("t4_s_sel", 128'(s_o.sel), 128'(4'hF));
    chk("t4_ack", 128'(m1_o.ack), 128'(1'b1));
    step();
    m1_i.stb = 1'b0;
    m1_i.cyc = 1'b0;
    step();
    @(negedge clk);
    chk("t4_no_drain", 128'(busy_o), 128'(1'b0));

    // m0 aborts with two reads in flight (err, rty): DRAIN swallows both, then m1.
    step();
    slv_delay = 4;
    slv_kind = 1;
    m0_i = '{cyc: 1'b1, stb: 1'b1, we: 1'b0, adr: 32'h400, dat: 32'h0, sel: 4'hF};
    step();
    step();
    m0_i.adr = 32'h404;
    slv_kind = 2;
    step();
    m0_i = '0;
    m1_i = '{cyc: 1'b1, stb: 1'b0, we: 1'b0, adr: 32'h0, dat: 32'h0, sel: 4'h0};
    slv_kind = 0;
    step();
    @(negedge clk);
    chk("t5_drain_busy", 128'(busy_o), 128'(1'b1));
    chk("t5_drain_gnt", 128'(gnt_o), 128'(2'b00));
    swallowed = 0;
    guard = 0;
    while (gnt_o != 2'b10 && guard < 50) begin
      if ((s_i.ack | s_i.err | s_i.rty) &&
          !(m0_o.ack | m0_o.err | m0_o.rty | m1_o.ack | m1_o.err | m1_o.rty)) swallowed++;
      step();
      @(negedge clk);
      guard++;
    end
    chk("t5_swallowed", 128'(swallowed), 128'(2));
    chk("t5_m1_gnt", 128'(gnt_o), 128'(2'b10));
    step();
    m1_i.cyc = 1'b0;
    step();
    step();

    // Reset while m1 holds 3 outstanding reads; late acks must not reach m0.
    slv_delay = 6;
    m1_i = '{cyc: 1'b1, stb: 1'b1, we: 1'b0, adr: 32'h500, dat: 32'h0, sel: 4'hF};
    step();
    step();
    m1_i.adr = 32'h504;
    step();
    m1_i.adr = 32'h508;
    step();
    m1_i.stb = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", 128'(gnt_o), 128'(2'b00));
    chk("t6_rst_cyc", 128'(s_o.cyc), 128'(1'b0));
    chk("t6_rst_m0_stall", 128'(m0_o.stall), 128'(1'b1));
    chk("t6_rst_m1_stall", 128'(m1_o.stall), 128'(1'b1));
    m1_i = '0;
    step();
    step();
    rst_n = 1'b1;
    base0 = rsp_cnt0;
    guard = 0;
    while (head_v && guard < 50) begin
      step();
      guard++;
    end
    chk("t6_late_acks_done", 128'(head_v), 128'(1'b0));
    slv_delay = 1;
    m0_i = '{cyc: 1'b1, stb: 1'b1, we: 1'b0, adr: 32'h600, dat: 32'h0, sel: 4'hF};
    step();
    @(negedge clk);
    chk("t6_m0_gnt", 128'(gnt_o), 128'(2'b01));
    step();
    m0_i.stb = 1'b0;
    @(negedge clk);
    chk("t6_m0_ack", 128'(m0_o.ack), 128'(1'b1));
    chk("t6_m0_dat", 128'(m0_o.dat), 128'(32'h5A5A_0600));
    step();
    m0_i.cyc = 1'b0;
    step();
    step();
    chk("t6_m0_rsp_cnt", 128'(rsp_cnt0 - base0), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
